// File: rtl/rob_pkg.sv
// Shared reorder-buffer configuration: sizing, instruction kind codes and entry layout.
package rob_pkg;

    localparam int unsigned ROB_SIZE       = 16;
    localparam int unsigned ROB_SIZE_WIDTH = 4;

    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;
    localparam logic [1:0] KIND_EXIT   = 2'd3;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
        logic [31:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob.sv
// In-order reorder buffer: allocates at tail, captures RS/LSB write-backs,
// commits one instruction per cycle from head and flushes on branch mispredict.
module rob
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,

    input  logic                      issue_valid,
    input  logic [1:0]                issue_kind,
    input  logic [4:0]                issue_rd,
    input  logic [31:0]               issue_pc,
    input  logic [31:0]               issue_target,
    input  logic                      issue_pred_taken,
    output logic [ROB_SIZE_WIDTH-1:0] tail_id,
    output logic                      rob_full,

    input  logic [ROB_SIZE_WIDTH-1:0] q1_id,
    input  logic [ROB_SIZE_WIDTH-1:0] q2_id,
    output logic                      q1_ready,
    output logic                      q2_ready,
    output logic [31:0]               q1_value,
    output logic [31:0]               q2_value,

    input  logic                      rs_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]               rs_value,
    input  logic                      lsb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,

    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic [31:0]               commit_value,
    output logic                      store_commit,
    output logic [ROB_SIZE_WIDTH-1:0] store_rob_id,
    output logic                      rob_clear,
    output logic [31:0]               clear_pc,
    output logic                      halt
);

    localparam int unsigned W = ROB_SIZE_WIDTH;

    rob_entry_t          entries_q [ROB_SIZE];
    rob_entry_t          entries_d [ROB_SIZE];
    logic [W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [W:0]          count_q, count_d;

    logic                commit_valid_q, commit_valid_d;
    logic [4:0]          commit_rd_q, commit_rd_d;
    logic [W-1:0]        commit_rob_id_q, commit_rob_id_d;
    logic [31:0]         commit_value_q, commit_value_d;
    logic                store_commit_q, store_commit_d;
    logic [W-1:0]        store_rob_id_q, store_rob_id_d;
    logic                rob_clear_q, rob_clear_d;
    logic [31:0]         clear_pc_q, clear_pc_d;
    logic                halt_q, halt_d;

    logic                do_issue, do_commit;
    rob_entry_t          head_e;

    // Operand lookup with same-cycle bypass from the write-back buses (RS first).
    function automatic logic [32:0] query(input logic [W-1:0] id);
        if (rs_ready && rs_rob_id == id) begin
            return {1'b1, rs_value};
        end else if (lsb_ready && lsb_rob_id == id) begin
            return {1'b1, lsb_value};
        end
        return {entries_q[id].ready, entries_q[id].value};
    endfunction

    assign rob_full = (count_q == (W + 1)'(ROB_SIZE));
    assign tail_id  = tail_q;

    // Combinational operand query ports.
    always_comb begin
        {q1_ready, q1_value} = query(q1_id);
        {q2_ready, q2_value} = query(q2_id);
    end

    // Next-state: flush, write-back, commit from head, issue at tail.
    always_comb begin
        entries_d       = entries_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_valid_d  = 1'b0;
        commit_rd_d     = commit_rd_q;
        commit_rob_id_d = commit_rob_id_q;
        commit_value_d  = commit_value_q;
        store_commit_d  = 1'b0;
        store_rob_id_d  = store_rob_id_q;
        rob_clear_d     = 1'b0;
        clear_pc_d      = clear_pc_q;
        halt_d          = halt_q;
        head_e          = entries_q[head_q];
        do_issue        = issue_valid && !rob_full;
        do_commit       = head_e.busy && head_e.ready;

        if (rob_clear_q) begin
            // Flush cycle: no commit, everything issued or written back is dropped.
            for (int i = 0; i < int'(ROB_SIZE); i++) entries_d[i] = '0;
            head_d          = '0;
            tail_d          = '0;
            count_d         = '0;
            commit_rd_d     = '0;
            commit_rob_id_d = '0;
            commit_value_d  = '0;
            store_rob_id_d  = '0;
            clear_pc_d      = '0;
        end else begin
            // LSB applied first so RS overrides on an (illegal) id collision.
            if (lsb_ready && entries_q[lsb_rob_id].busy) begin
                entries_d[lsb_rob_id].value = lsb_value;
                entries_d[lsb_rob_id].ready = 1'b1;
            end
            if (rs_ready && entries_q[rs_rob_id].busy) begin
                entries_d[rs_rob_id].value = rs_value;
                entries_d[rs_rob_id].ready = 1'b1;
            end

            if (do_commit) begin
                case (head_e.kind)
                    KIND_REG: begin
                        commit_valid_d  = 1'b1;
                        commit_rd_d     = head_e.rd;
                        commit_rob_id_d = head_q;
                        commit_value_d  = head_e.value;
                    end
                    KIND_STORE: begin
                        store_commit_d = 1'b1;
                        store_rob_id_d = head_q;
                    end
                    KIND_BRANCH: begin
                        if (head_e.value[0] != head_e.pred) begin
                            rob_clear_d = 1'b1;
                            clear_pc_d  = head_e.value[0] ? head_e.target : head_e.pc + 32'd4;
                        end
                    end
                    default: halt_d = 1'b1;
                endcase
                entries_d[head_q].busy  = 1'b0;
                entries_d[head_q].ready = 1'b0;
                head_d = head_q + W'(1);
            end

            if (do_issue) begin
                entries_d[tail_q] = '{
                    busy:   1'b1,
                    ready:  (issue_kind == KIND_EXIT),
                    kind:   issue_kind,
                    rd:     issue_rd,
                    pc:     issue_pc,
                    target: issue_target,
                    pred:   issue_pred_taken,
                    value:  32'd0
                };
                tail_d = tail_q + W'(1);
            end

            count_d = count_q + (W + 1)'(do_issue) - (W + 1)'(do_commit);
        end
    end

    // State register: synchronous reset, hold everything while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ROB_SIZE); i++) entries_q[i] <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_rd_q     <= '0;
            commit_rob_id_q <= '0;
            commit_value_q  <= '0;
            store_commit_q  <= 1'b0;
            store_rob_id_q  <= '0;
            rob_clear_q     <= 1'b0;
            clear_pc_q      <= '0;
            halt_q          <= 1'b0;
        end else if (rdy) begin
            entries_q       <= entries_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_valid_q  <= commit_valid_d;
            commit_rd_q     <= commit_rd_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_value_q  <= commit_value_d;
            store_commit_q  <= store_commit_d;
            store_rob_id_q  <= store_rob_id_d;
            rob_clear_q     <= rob_clear_d;
            clear_pc_q      <= clear_pc_d;
            halt_q          <= halt_d;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_rd     = commit_rd_q;
    assign commit_rob_id = commit_rob_id_q;
    assign commit_value  = commit_value_q;
    assign store_commit  = store_commit_q;
    assign store_rob_id  = store_rob_id_q;
    assign rob_clear     = rob_clear_q;
    assign clear_pc      = clear_pc_q;
    assign halt          = halt_q;

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for the reorder buffer.
module tb_rob;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_kind = 2'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic [31:0] issue_pc = 32'd0;
    logic [31:0] issue_target = 32'd0;
    logic        issue_pred_taken = 1'b0;
    logic [3:0]  tail_id;
    logic        rob_full;
    logic [3:0]  q1_id = 4'd0, q2_id = 4'd0;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        rs_ready = 1'b0;
    logic [3:0]  rs_rob_id = 4'd0;
    logic [31:0] rs_value = 32'd0;
    logic        lsb_ready = 1'b0;
    logic [3:0]  lsb_rob_id = 4'd0;
    logic [31:0] lsb_value = 32'd0;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        store_commit;
    logic [3:0]  store_rob_id;
    logic        rob_clear;
    logic [31:0] clear_pc;
    logic        halt;

    int n_checks = 0;
    int n_errors = 0;

    rob dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .issue_valid      (issue_valid),
        .issue_kind       (issue_kind),
        .issue_rd         (issue_rd),
        .issue_pc         (issue_pc),
        .issue_target     (issue_target),
        .issue_pred_taken (issue_pred_taken),
        .tail_id          (tail_id),
        .rob_full         (rob_full),
        .q1_id            (q1_id),
        .q2_id            (q2_id),
        .q1_ready         (q1_ready),
        .q2_ready         (q2_ready),
        .q1_value         (q1_value),
        .q2_value         (q2_value),
        .rs_ready         (rs_ready),
        .rs_rob_id        (rs_rob_id),
        .rs_value         (rs_value),
        .lsb_ready        (lsb_ready),
        .lsb_rob_id       (lsb_rob_id),
        .lsb_value        (lsb_value),
        .commit_valid     (commit_valid),
        .commit_rd        (commit_rd),
        .commit_rob_id    (commit_rob_id),
        .commit_value     (commit_value),
        .store_commit     (store_commit),
        .store_rob_id     (store_rob_id),
        .rob_clear        (rob_clear),
        .clear_pc         (clear_pc),
        .halt             (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        rs_ready = 1'b0;
        lsb_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic pred);
        issue_valid = 1'b1;
        issue_kind = kind;
        issue_rd = rd;
        issue_pc = pc;
        issue_target = tgt;
        issue_pred_taken = pred;
    endtask

    task automatic rs_wb(input logic [3:0] id, input logic [31:0] val);
        rs_ready = 1'b1;
        rs_rob_id = id;
        rs_value = val;
    endtask

    // Issue a branch at id 0, resolve it via RS, and check the flush it causes.
    task automatic branch_case(input logic pred, input logic actual, input logic exp_clear,
                               input logic [31:0] exp_pc);
        do_reset();
        set_issue(2'd2, 5'd0, 32'h100, 32'h200, pred);
        step();
        issue_valid = 1'b0;
        rs_wb(4'd0, {31'd0, actual});
        step();
        rs_ready = 1'b0;
        step();
        check("br_clear", 32'(rob_clear), 32'(exp_clear));
        if (exp_clear) check("br_clear_pc", clear_pc, exp_pc);
        check("br_no_commit", 32'(commit_valid), 32'd0);
        step();
        check("br_clear_pulse", 32'(rob_clear), 32'd0);
        check("br_tail_after", 32'(tail_id), exp_clear ? 32'd0 : 32'd1);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_tail", 32'(tail_id), 32'd0);
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_commit", 32'(commit_valid), 32'd0);
        check("rst_store", 32'(store_commit), 32'd0);
        check("rst_clear", 32'(rob_clear), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);

        // Three reg ops, out-of-order write-back, in-order commit
        for (int i = 0; i < 3; i++) begin
            check("t1_tail", 32'(tail_id), 32'(i));
            set_issue(2'd0, 5'(i + 1), 32'h0, 32'h0, 1'b0);
            step();
        end
        issue_valid = 1'b0;
        check("t1_tail3", 32'(tail_id), 32'd3);
        rs_wb(4'd2, 32'h11); step();
        rs_wb(4'd1, 32'h22); step();
        check("t1_no_early", 32'(commit_valid), 32'd0);
        rs_wb(4'd0, 32'h33); step();
        rs_ready = 1'b0;
        check("t1_no_early0", 32'(commit_valid), 32'd0);
        step();
        check("t1_c0_v", 32'(commit_valid), 32'd1);
        check("t1_c0_id", 32'(commit_rob_id), 32'd0);
        check("t1_c0_val", commit_value, 32'h33);
        check("t1_c0_rd", 32'(commit_rd), 32'd1);
        step();
        check("t1_c1_v", 32'(commit_valid), 32'd1);
        check("t1_c1_id", 32'(commit_rob_id), 32'd1);
        check("t1_c1_val", commit_value, 32'h22);
        step();
        check("t1_c2_v", 32'(commit_valid), 32'd1);
        check("t1_c2_id", 32'(commit_rob_id), 32'd2);
        check("t1_c2_val", commit_value, 32'h11);
        check("t1_c2_rd", 32'(commit_rd), 32'd3);
        step();
        check("t1_idle", 32'(commit_valid), 32'd0);

        // Fill, overflow issue ignored, one commit, wrap-around reuse of id 0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(2'd0, 5'd5, 32'h0, 32'h0, 1'b0);
            step();
        end
        check("t2_full", 32'(rob_full), 32'd1);
        check("t2_tail_wrap", 32'(tail_id), 32'd0);
        step(); // 17th issue attempt
        issue_valid = 1'b0;
        check("t2_ignored_tail", 32'(tail_id), 32'd0);
        check("t2_still_full", 32'(rob_full), 32'd1);
        rs_wb(4'd0, 32'hABCD); step();
        rs_ready = 1'b0;
        step();
        check("t2_commit_v", 32'(commit_valid), 32'd1);
        check("t2_commit_id", 32'(commit_rob_id), 32'd0);
        check("t2_commit_val", commit_value, 32'hABCD);
        check("t2_not_full", 32'(rob_full), 32'd0);
        set_issue(2'd0, 5'd6, 32'h0, 32'h0, 1'b0);
        step();
        issue_valid = 1'b0;
        check("t2_reuse_tail", 32'(tail_id), 32'd1);
        check("t2_full_again", 32'(rob_full), 32'd1);

        // Branch mispredicts (taken, not-taken) and a correct prediction
        branch_case(1'b0, 1'b1, 1'b1, 32'h200);
        branch_case(1'b1, 1'b0, 1'b1, 32'h104);
        branch_case(1'b1, 1'b1, 1'b0, 32'h0);

        // Issue in the same cycle as a mispredict commit is flushed
        do_reset();
        set_issue(2'd2, 5'd0, 32'h100, 32'h200, 1'b0);
        step();
        issue_valid = 1'b0;
        rs_wb(4'd0, 32'd1);
        step();
        rs_ready = 1'b0;
        set_issue(2'd0, 5'd9, 32'h0, 32'h0, 1'b0);
        step();
        issue_valid = 1'b0;
        check("t3_clear", 32'(rob_clear), 32'd1);
        check("t3_tail_pre", 32'(tail_id), 32'd2);
        step();
        check("t3_tail_flushed", 32'(tail_id), 32'd0);
        check("t3_clear_off", 32'(rob_clear), 32'd0);

        // Query bypass from both buses, then stored values
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_issue(2'd0, 5'd1, 32'h0, 32'h0, 1'b0);
            step();
        end
        issue_valid = 1'b0;
        q1_id = 4'd5;
        q2_id = 4'd4;
        #1;
        check("q_pre_ready", 32'(q1_ready), 32'd0);
        rs_wb(4'd5, 32'hDEAD);
        lsb_ready = 1'b1; lsb_rob_id = 4'd4; lsb_value = 32'hBEEF;
        #1;
        check("q1_byp_ready", 32'(q1_ready), 32'd1);
        check("q1_byp_val", q1_value, 32'hDEAD);
        check("q2_byp_ready", 32'(q2_ready), 32'd1);
        check("q2_byp_val", q2_value, 32'hBEEF);
        step();
        rs_ready = 1'b0;
        lsb_ready = 1'b0;
        q2_id = 4'd3;
        #1;
        check("q1_stored_val", q1_value, 32'hDEAD);
        check("q2_not_ready", 32'(q2_ready), 32'd0);

        // Store commit after a reg commit
        do_reset();
        set_issue(2'd0, 5'd4, 32'h0, 32'h0, 1'b0); step();
        set_issue(2'd1, 5'd0, 32'h0, 32'h0, 1'b0); step();
        issue_valid = 1'b0;
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_value = 32'h0; step();
        lsb_ready = 1'b0;
        rs_wb(4'd0, 32'h77); step();
        rs_ready = 1'b0;
        step();
        check("st_reg_commit", 32'(commit_valid), 32'd1);
        check("st_not_yet", 32'(store_commit), 32'd0);
        step();
        check("st_commit", 32'(store_commit), 32'd1);
        check("st_id", 32'(store_rob_id), 32'd1);
        check("st_no_reg", 32'(commit_valid), 32'd0);

        // rdy low freezes a ready head and ignores issue
        do_reset();
        set_issue(2'd0, 5'd7, 32'h0, 32'h0, 1'b0); step();
        issue_valid = 1'b0;
        rs_wb(4'd0, 32'h55); step();
        rs_ready = 1'b0;
        rdy = 1'b0;
        set_issue(2'd0, 5'd8, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdy_no_commit", 32'(commit_valid), 32'd0);
            check("rdy_tail_hold", 32'(tail_id), 32'd1);
        end
        issue_valid = 1'b0;
        rdy = 1'b1;
        step();
        check("rdy_commit", 32'(commit_valid), 32'd1);
        check("rdy_commit_val", commit_value, 32'h55);
        check("rdy_commit_rd", 32'(commit_rd), 32'd7);

        // Exit commits immediately from head, halt sticks until reset
        do_reset();
        set_issue(2'd3, 5'd0, 32'h0, 32'h0, 1'b0); step();
        issue_valid = 1'b0;
        check("halt_not_yet", 32'(halt), 32'd0);
        step();
        check("halt_set", 32'(halt), 32'd1);
        step(); step();
        check("halt_sticky", 32'(halt), 32'd1);
        do_reset();
        check("halt_reset", 32'(halt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
